// File: rtl/comparador_pkg.sv
// Shared encodings for the left-to-right comparison cell and its serial wrapper.
package comparador_pkg;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_GT = 2'b01,
        REL_LT = 2'b10
    } rel_t;

    typedef enum logic [1:0] {
        MODE_LE = 2'b00,
        MODE_LT = 2'b01,
        MODE_EQ = 2'b10,
        MODE_GT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Maps the final A-vs-B relation onto the requested predicate.
    function automatic logic eval_mode(input rel_t rel, input mode_t mode);
        logic z;
        z = 1'b0;
        case (mode)
            MODE_LE: z = (rel == REL_LT) || (rel == REL_EQ);
            MODE_LT: z = (rel == REL_LT);
            MODE_EQ: z = (rel == REL_EQ);
            MODE_GT: z = (rel == REL_GT);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/celda_comparadora.sv
// Single iterative cell of the MSB-first comparison chain: folds one bit pair
// into the running relation. Purely combinational.
module celda_comparadora
    import comparador_pkg::*;
(
    input  rel_t rel,
    input  logic a,
    input  logic b,
    output rel_t rel_next
);

    always_comb begin
        rel_next = rel;
        // GT and LT are absorbing; only an undecided relation can change
        if (rel == REL_EQ && a != b)
            rel_next = a ? REL_GT : REL_LT;
    end

endmodule

// File: rtl/comparador_serial_izq_der.sv
// Serial MSB-first unsigned comparator, one bit per clock, with start/busy/done.
// Optional macro EARLY_TERM_EN: finish at the first differing bit pair.
module comparador_serial_izq_der
    import comparador_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic         done,
    output logic         Zout
);

    localparam int IW = $clog2(N);

    state_t          state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    mode_t           mode_reg;
    logic [IW-1:0]   idx;
    rel_t            rel;
    rel_t            rel_next;
    logic            finish;

    celda_comparadora u_celda (
        .rel      (rel),
        .a        (a_reg[idx]),
        .b        (b_reg[idx]),
        .rel_next (rel_next)
    );

`ifdef EARLY_TERM_EN
    // Relation is still EQ on entry to every SHIFT edge here, so any change
    // means this bit pair decided the outcome.
    assign finish = (idx == '0) || (rel_next != REL_EQ);
`else
    assign finish = (idx == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= MODE_LE;
            idx      <= '0;
            rel      <= REL_EQ;
            busy     <= 1'b0;
            done     <= 1'b0;
            Zout     <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a start too, giving N+1 cycle back-to-back spacing
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        mode_reg <= mode_t'(mode);
                        idx      <= IW'(N - 1);
                        rel      <= REL_EQ;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    rel <= rel_next;
                    if (finish) begin
                        state <= DONE;
                        done  <= 1'b1;
                        Zout  <= eval_mode(rel_next, mode_reg);
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Scoreboard bench for the serial comparator (N=4 and N=8 instances).
module tb_comparador_serial_izq_der;

    typedef struct {
        logic z;
        int   lat;
        int   k;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] A4 = '0, B4 = '0;
    logic [7:0] A8 = '0, B8 = '0;
    logic [1:0] mode4 = '0, mode8 = '0;
    logic       busy4, done4, Zout4, busy8, done8, Zout8;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q4[$];
    exp_t q8[$];
    logic last4 = 1'b0, last8 = 1'b0;

    comparador_serial_izq_der #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .mode(mode4),
        .busy(busy4), .done(done4), .Zout(Zout4)
    );

    comparador_serial_izq_der #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .mode(mode8),
        .busy(busy8), .done(done8), .Zout(Zout8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: plain arithmetic comparison of the two unsigned values.
    function automatic logic ref_z(input int a, input int b, input logic [1:0] m);
        case (m)
            2'b00:   return a <= b;
            2'b01:   return a < b;
            2'b10:   return a == b;
            default: return a > b;
        endcase
    endfunction

    function automatic int ref_lat(input int a, input int b, input int n);
`ifdef EARLY_TERM_EN
        for (int i = n - 1; i >= 0; i--)
            if (((a >> i) & 1) != ((b >> i) & 1)) return n - i;
`endif
        return n;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: pop on every done pulse; between pulses Zout must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst) last4 = 1'b0;
        else if (done4) begin
            if (q4.size() == 0) check("n4_unexpected_done", 1, 0);
            else begin
                e = q4.pop_front();
                check("n4_zout", int'(Zout4), int'(e.z));
                check("n4_latency", cyc - e.k, e.lat);
            end
            last4 = Zout4;
        end else if (Zout4 !== last4) check("n4_zout_hold", int'(Zout4), int'(last4));
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) last8 = 1'b0;
        else if (done8) begin
            if (q8.size() == 0) check("n8_unexpected_done", 1, 0);
            else begin
                e = q8.pop_front();
                check("n8_zout", int'(Zout8), int'(e.z));
                check("n8_latency", cyc - e.k, e.lat);
            end
            last8 = Zout8;
        end else if (Zout8 !== last8) check("n8_zout_hold", int'(Zout8), int'(last8));
    end

    task automatic wait_idle4();
        int n = 0;
        while (busy4 && n < 100) begin @(negedge clk); n++; end
        if (busy4) check("n4_idle_timeout", 1, 0);
    endtask

    task automatic issue4(input int a, input int b, input logic [1:0] m, input bit push);
        wait_idle4();
        A4 = 4'(a); B4 = 4'(b); mode4 = m; start4 = 1'b1;
        if (push) q4.push_back('{ref_z(a, b, m), ref_lat(a, b, 4), cyc + 1});
        @(negedge clk);
        start4 = 1'b0;
        // scribble operands after acceptance; result must not change
        A4 = 4'($urandom); B4 = 4'($urandom); mode4 = 2'($urandom);
    endtask

    task automatic issue8(input int a, input int b, input logic [1:0] m);
        int n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        if (busy8) check("n8_idle_timeout", 1, 0);
        A8 = 8'(a); B8 = 8'(b); mode8 = m; start8 = 1'b1;
        q8.push_back('{ref_z(a, b, m), ref_lat(a, b, 8), cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        A8 = 8'($urandom); B8 = 8'($urandom);
    endtask

    initial begin
        int next_acc, pushes, guard, a, b;
        logic [1:0] m;

        repeat (3) @(negedge clk);
        check("reset_busy4", int'(busy4), 0);
        check("reset_done4", int'(done4), 0);
        check("reset_zout4", int'(Zout4), 0);
        check("reset_busy8", int'(busy8), 0);
        rst = 1'b0;
        @(negedge clk);

        issue4(4'b1010, 4'b0100, 2'b00, 1);
        issue4(4'b0011, 4'b0100, 2'b00, 1);
        issue4(0, 0, 2'b00, 1);
        issue4(0, 0, 2'b01, 1);
        issue4(0, 0, 2'b10, 1);
        issue4(4'b1000, 4'b0000, 2'b11, 1);
        issue4(4'b0111, 4'b0111, 2'b11, 1);
        for (int i = 0; i < 30; i++)
            issue4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   2'($urandom), 1);

        // start held high; operands change every cycle, only accepted ones count
        wait_idle4();
        start4 = 1'b1;
        next_acc = cyc + 1;
        pushes = 0;
        guard = 0;
        while (pushes < 4 && guard < 200) begin
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 1) == 1) ? a : int'($urandom_range(0, 15));
            m = 2'($urandom);
            A4 = 4'(a); B4 = 4'(b); mode4 = m;
            if (cyc + 1 == next_acc) begin
                q4.push_back('{ref_z(a, b, m), ref_lat(a, b, 4), next_acc});
                next_acc += ref_lat(a, b, 4) + 1;
                pushes++;
            end
            @(negedge clk);
            guard++;
        end
        start4 = 1'b0;

        // abort mid-comparison: equal operands keep it in SHIFT in both builds
        issue4(4'b0101, 4'b0101, 2'b10, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy4), 0);
        check("abort_done", int'(done4), 0);
        check("abort_zout", int'(Zout4), 0);
        repeat (6) @(negedge clk);
        issue4(4'b0110, 4'b0101, 2'b11, 1);

        issue8(255, 255, 2'b00);
        issue8(0, 128, 2'b00);
        issue8(200, 201, 2'b01);
        for (int i = 0; i < 10; i++)
            issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2'($urandom));

        guard = 0;
        while ((q4.size() != 0 || q8.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_n4", q4.size(), 0);
        check("drain_n8", q8.size(), 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
